// File: rtl/controlador_busca_if.sv
// Fetch bus: instruction-memory port, decode handshake and control.
interface controlador_busca_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned CNT_WIDTH = 32;

  logic [ADDR_WIDTH-1:0] mem_endereco;
  logic [DATA_WIDTH-1:0] mem_instrucao;
  logic [DATA_WIDTH-1:0] instrucao;
  logic [ADDR_WIDTH-1:0] pc_instrucao;
  logic                  valido;
  logic                  pronto;
  logic                  desvio;
  logic [ADDR_WIDTH-1:0] alvo;
  logic                  parar;
  logic                  continuar;
  logic                  parado;
  logic [CNT_WIDTH-1:0]  contador_instr;
  logic                  erro;

  // Fetch controller side.
  modport master (
    output mem_endereco,
    input  mem_instrucao,
    output instrucao,
    output pc_instrucao,
    output valido,
    input  pronto,
    input  desvio,
    input  alvo,
    input  parar,
    input  continuar,
    output parado,
    output contador_instr,
    output erro
  );

  // Memory / decode / control environment side.
  modport slave (
    input  mem_endereco,
    output mem_instrucao,
    input  instrucao,
    input  pc_instrucao,
    input  valido,
    output pronto,
    output desvio,
    output alvo,
    output parar,
    output continuar,
    input  parado,
    input  contador_instr,
    input  erro
  );
endinterface

// File: rtl/controlador_busca.sv
// Instruction-fetch sequencer: owns the PC, buffers one fetched word for
// decode behind a valid/ready handshake, handles redirect, halt/resume and
// counts retired fetches.
// Optional macro BOUNDS_CHECK_EN: out-of-range targets or running off the end
// of memory raise a sticky erro and park in PARADO instead of wrapping to 0.
module controlador_busca #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 100,
  parameter int unsigned RESET_PC   = 0
) (
  input logic                 clock,
  input logic                 reset_n,
  controlador_busca_if.master bus
);

  localparam int unsigned CNT_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET  = ADDR_WIDTH'(RESET_PC);

  typedef enum logic {
    BUSCA  = 1'b0,
    PARADO = 1'b1
  } estado_t;

  estado_t               estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_instr_q, pc_instr_d;
  logic                  valido_q, valido_d;
  logic [CNT_WIDTH-1:0]  contador_q, contador_d;
  logic                  xfer;
  logic                  alvo_ok;
  logic [ADDR_WIDTH-1:0] pc_next;
`ifdef BOUNDS_CHECK_EN
  logic                  erro_q, erro_d;
`endif

  // Sequential address after PC, wrapping at the end of memory.
  assign pc_next = (pc_q == LAST_ADDR) ? '0 : pc_q + ADDR_WIDTH'(1);
  assign alvo_ok = (bus.alvo <= LAST_ADDR);
  assign xfer    = valido_q && bus.pronto;

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) estado_q <= BUSCA;
    else          estado_q <= estado_d;
  end

  // Next state and next datapath values; redirect is applied last so it wins.
  always_comb begin
    estado_d   = estado_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_instr_d = pc_instr_q;
    valido_d   = valido_q;
    contador_d = contador_q;
`ifdef BOUNDS_CHECK_EN
    erro_d     = erro_q;
`endif

    // A transferred word leaves the buffer unless a load refills it below.
    if (xfer) begin
      contador_d = contador_q + CNT_WIDTH'(1);
      valido_d   = 1'b0;
    end

    case (estado_q)
      BUSCA: begin
        if (bus.parar) begin
          estado_d = PARADO;
        end else if (!bus.desvio && (!valido_q || bus.pronto)) begin
`ifdef BOUNDS_CHECK_EN
          if (pc_q == LAST_ADDR) begin
            erro_d   = 1'b1;
            valido_d = 1'b0;
            estado_d = PARADO;
          end else begin
            instr_d    = bus.mem_instrucao;
            pc_instr_d = pc_q;
            valido_d   = 1'b1;
            pc_d       = pc_next;
          end
`else
          instr_d    = bus.mem_instrucao;
          pc_instr_d = pc_q;
          valido_d   = 1'b1;
          pc_d       = pc_next;
`endif
        end
      end
      PARADO: begin
`ifdef BOUNDS_CHECK_EN
        if (bus.continuar && !bus.parar && !erro_q) estado_d = BUSCA;
`else
        if (bus.continuar && !bus.parar) estado_d = BUSCA;
`endif
      end
    endcase

    if (bus.desvio) begin
      valido_d = 1'b0;
`ifdef BOUNDS_CHECK_EN
      if (alvo_ok) begin
        pc_d = bus.alvo;
      end else begin
        erro_d   = 1'b1;
        estado_d = PARADO;
      end
`else
      pc_d = alvo_ok ? bus.alvo : '0;
`endif
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q       <= PC_RESET;
      instr_q    <= '0;
      pc_instr_q <= '0;
      valido_q   <= 1'b0;
      contador_q <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_instr_q <= pc_instr_d;
      valido_q   <= valido_d;
      contador_q <= contador_d;
    end
  end

`ifdef BOUNDS_CHECK_EN
  // Sticky illegal-address flag.
  always_ff @(posedge clock) begin
    if (!reset_n) erro_q <= 1'b0;
    else          erro_q <= erro_d;
  end
  assign bus.erro = erro_q;
`else
  assign bus.erro = 1'b0;
`endif

  assign bus.mem_endereco   = pc_q;
  assign bus.instrucao      = instr_q;
  assign bus.pc_instrucao   = pc_instr_q;
  assign bus.valido         = valido_q;
  assign bus.parado         = (estado_q == PARADO);
  assign bus.contador_instr = contador_q;

endmodule

// File: tb/tb_controlador_busca.sv
// Bench for controlador_busca: directed plan scenarios plus random traffic,
// checked against a transaction-level model of the fetch buffer.
module tb_controlador_busca;

  localparam int MEM_DEPTH = 100;
  localparam int RESET_PC  = 0;

  logic clock;
  logic reset_n;
  logic [31:0] mem [0:MEM_DEPTH-1];

  int n_testes = 0;
  int n_falhas = 0;

  // Reference model state
  int          m_pc;
  logic        m_val;
  logic [31:0] m_ins;
  int          m_pci;
  logic [31:0] m_cnt;
  logic        m_par;

  controlador_busca_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  controlador_busca #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .MEM_DEPTH (MEM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  assign bus.mem_instrucao = (bus.mem_endereco < 32'(MEM_DEPTH))
                             ? mem[7'(bus.mem_endereco)] : 32'h0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic verifica(input string tag, input logic [63:0] obs, input logic [63:0] esp);
    n_testes++;
    if (obs !== esp) begin
      n_falhas++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, from the current inputs.
  task automatic modelo_borda();
    logic xfer;
    if (!reset_n) begin
      m_pc = RESET_PC; m_val = 1'b0; m_ins = '0; m_pci = 0; m_cnt = '0; m_par = 1'b0;
      return;
    end
    xfer = m_val && bus.pronto;
    if (xfer) m_cnt = m_cnt + 32'd1;
    if (bus.desvio) begin
      m_pc  = (bus.alvo < 32'(MEM_DEPTH)) ? int'(bus.alvo) : 0;
      m_val = 1'b0;
    end else if (!m_par && !bus.parar && (!m_val || bus.pronto)) begin
      m_ins = mem[m_pc];
      m_pci = m_pc;
      m_val = 1'b1;
      m_pc  = (m_pc + 1) % MEM_DEPTH;
    end else if (xfer) begin
      m_val = 1'b0;
    end
    if (!m_par) m_par = bus.parar;
    else if (bus.continuar && !bus.parar) m_par = 1'b0;
  endtask

  task automatic confere();
    verifica("valido", 64'(bus.valido), 64'(m_val));
    verifica("parado", 64'(bus.parado), 64'(m_par));
    verifica("contador_instr", 64'(bus.contador_instr), 64'(m_cnt));
    verifica("mem_endereco", 64'(bus.mem_endereco), 64'(m_pc));
    verifica("erro", 64'(bus.erro), 64'(0));
    if (m_val) begin
      verifica("instrucao", 64'(bus.instrucao), 64'(m_ins));
      verifica("pc_instrucao", 64'(bus.pc_instrucao), 64'(m_pci));
    end
  endtask

  // Advance one cycle, update the model and check outputs just after the edge.
  task automatic ciclo();
    @(posedge clock);
    modelo_borda();
    #1;
    confere();
  endtask

  initial begin
    logic [31:0] plan [0:3];
    plan[0] = 32'h08801000; plan[1] = 32'h08C01000;
    plan[2] = 32'h09001000; plan[3] = 32'h09401000;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[i] = plan[i];

    reset_n = 1'b0; bus.pronto = 1'b1; bus.desvio = 1'b0; bus.alvo = '0;
    bus.parar = 1'b0; bus.continuar = 1'b0;
    ciclo(); ciclo();
    verifica("rst_valido", 64'(bus.valido), 64'(0));
    verifica("rst_contador", 64'(bus.contador_instr), 64'(0));
    verifica("rst_mem_endereco", 64'(bus.mem_endereco), 64'(RESET_PC));

    // Sequential fetch with one stall on word 1
    reset_n = 1'b1;
    ciclo();
    verifica("plan_w0", 64'(bus.instrucao), 64'(plan[0]));
    verifica("plan_pc0", 64'(bus.pc_instrucao), 64'(0));
    ciclo();
    bus.pronto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ciclo();
      verifica("stall_ins", 64'(bus.instrucao), 64'(plan[1]));
      verifica("stall_pci", 64'(bus.pc_instrucao), 64'(1));
      verifica("stall_end", 64'(bus.mem_endereco), 64'(2));
      verifica("stall_cnt", 64'(bus.contador_instr), 64'(1));
    end
    bus.pronto = 1'b1;
    ciclo();
    verifica("plan_w2", 64'(bus.instrucao), 64'(plan[2]));
    ciclo();
    verifica("plan_w3", 64'(bus.instrucao), 64'(plan[3]));
    verifica("plan_pc3", 64'(bus.pc_instrucao), 64'(3));
    ciclo();
    verifica("plan_cnt4", 64'(bus.contador_instr), 64'(4));

    // Redirect to 3 while word 1 is buffered
    bus.desvio = 1'b1; bus.alvo = 32'd1;
    ciclo();
    bus.desvio = 1'b0;
    ciclo();
    verifica("redir_pc1", 64'(bus.pc_instrucao), 64'(1));
    bus.desvio = 1'b1; bus.alvo = 32'd3;
    ciclo();
    verifica("redir_bubble", 64'(bus.valido), 64'(0));
    bus.desvio = 1'b0;
    ciclo();
    verifica("redir_ins", 64'(bus.instrucao), 64'(plan[3]));
    verifica("redir_pci", 64'(bus.pc_instrucao), 64'(3));

    // Wrap at the end of memory
    bus.desvio = 1'b1; bus.alvo = 32'd98;
    ciclo();
    bus.desvio = 1'b0;
    ciclo(); ciclo();
    verifica("wrap_99", 64'(bus.pc_instrucao), 64'(99));
    ciclo();
    verifica("wrap_0", 64'(bus.pc_instrucao), 64'(0));

    // Halt with word 2 buffered, drain, resume at 3
    bus.pronto = 1'b0; bus.desvio = 1'b1; bus.alvo = 32'd2;
    ciclo();
    bus.desvio = 1'b0;
    ciclo();
    bus.parar = 1'b1;
    ciclo();
    verifica("halt_held", 64'(bus.pc_instrucao), 64'(2));
    bus.parar = 1'b0; bus.pronto = 1'b1;
    ciclo();
    verifica("halt_drain", 64'(bus.valido), 64'(0));
    verifica("halt_parado", 64'(bus.parado), 64'(1));
    ciclo();
    bus.continuar = 1'b1;
    ciclo();
    bus.continuar = 1'b0;
    ciclo();
    verifica("resume_pci", 64'(bus.pc_instrucao), 64'(3));

    // Reset during a stall with a redirect pending
    bus.pronto = 1'b0;
    ciclo();
    reset_n = 1'b0; bus.desvio = 1'b1; bus.alvo = 32'd50;
    ciclo();
    verifica("rst2_valido", 64'(bus.valido), 64'(0));
    verifica("rst2_cnt", 64'(bus.contador_instr), 64'(0));
    verifica("rst2_end", 64'(bus.mem_endereco), 64'(RESET_PC));
    reset_n = 1'b1; bus.desvio = 1'b0; bus.pronto = 1'b1;
    ciclo();
    verifica("rst2_first", 64'(bus.pc_instrucao), 64'(RESET_PC));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n       = ($urandom_range(0, 99) != 0);
      bus.pronto    = ($urandom_range(0, 9) < 7);
      bus.desvio    = ($urandom_range(0, 9) == 0);
      bus.alvo      = 32'($urandom_range(0, 120));
      bus.parar     = ($urandom_range(0, 19) == 0);
      bus.continuar = ($urandom_range(0, 4) == 0);
      ciclo();
    end

    $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
    $finish;
  end

endmodule
